// File: rtl/mem_page_responder.sv
// mem_page_responder
//   Memory page slave for a paged controller bus. Owns one 4-bit page and a
//   4096 x 16 word store. A transaction starts with an address cycle that
//   carries {page, loc}. It then moves four 16-bit beats at loc..loc+3,
//   wrapping modulo 4096.
//   - Write: data is taken on the 4 cycles after the address cycle.
//   - Read: one turnaround cycle, then 4 registered read beats.
//
// Ports
//   clk          : single clock, rising edge
//   reset        : asynchronous, active-low
//   AddrValid    : address-cycle strobe from the controller
//   rw           : 1 = read, 0 = write (sampled with AddrValid)
//   AddrDataIn   : {page[15:12], loc[11:0]} in the address cycle, write data in write beats
//   DataOut      : read data during read beats, 16'h0000 otherwise
//   DataOutValid : high exactly while DataOut carries read data
//   Busy         : high while a transaction for this page is in progress
module mem_page_responder #(
    parameter logic [3:0]  PAGE  = 4'h1,  // MEMPAGE1
    parameter int unsigned DEPTH = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        AddrValid,
    input  logic        rw,
    input  logic [15:0] AddrDataIn,
    output logic [15:0] DataOut,
    output logic        DataOutValid,
    output logic        Busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WDATA = 2'd1,
        RTURN = 2'd2,
        RDATA = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [1:0]  r_beat;
    logic [1:0]  w_beat_next;
    logic [11:0] r_loc;
    logic [11:0] w_loc_next;

    logic [15:0] r_mem [DEPTH];  // not cleared by reset

    logic [11:0] w_mem_addr;
    logic        w_mem_we;
    logic        w_rd_en;
    logic [15:0] r_data_out;
    logic        r_data_valid;

    always_comb begin
        w_state_next = r_state;
        w_beat_next  = r_beat;
        w_loc_next   = r_loc;
        w_mem_we     = 1'b0;
        w_rd_en      = 1'b0;
        w_mem_addr   = r_loc + {10'd0, r_beat};

        unique case (r_state)
            IDLE: begin
                // Foreign pages are ignored entirely.
                if (AddrValid && (AddrDataIn[15:12] == PAGE)) begin
                    w_loc_next   = AddrDataIn[11:0];
                    w_beat_next  = 2'd0;
                    w_state_next = rw ? RTURN : WDATA;
                end
            end
            WDATA: begin
                w_mem_we    = 1'b1;
                w_beat_next = r_beat + 2'd1;
                if (r_beat == 2'd3) begin
                    w_state_next = IDLE;
                end
            end
            RTURN: begin
                // Prefetch beat 0 so it is on DataOut in the first RDATA cycle.
                w_rd_en      = 1'b1;
                w_state_next = RDATA;
            end
            RDATA: begin
                // DataOut shows word r_beat; fetch the following one.
                w_beat_next = r_beat + 2'd1;
                if (r_beat == 2'd3) begin
                    w_state_next = IDLE;
                end else begin
                    w_rd_en    = 1'b1;
                    w_mem_addr = r_loc + {10'd0, r_beat} + 12'd1;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_beat       <= 2'd0;
            r_loc        <= 12'd0;
            r_data_out   <= 16'h0000;
            r_data_valid <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_beat       <= w_beat_next;
            r_loc        <= w_loc_next;
            r_data_valid <= w_rd_en;
            r_data_out   <= w_rd_en ? r_mem[w_mem_addr] : 16'h0000;
        end
    end

    // Write enable is derived from r_state. Reset forces IDLE asynchronously,
    // so no beat is committed while reset is low.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_addr] <= AddrDataIn;
        end
    end

    assign DataOut      = r_data_out;
    assign DataOutValid = r_data_valid;
    assign Busy         = (r_state != IDLE);

endmodule
